sha256_block_ctrl: RTL
======================

// Module: sha256_block_ctrl
// PURPOSE
//  Iterative SHA-256 compression controller. Accepts 512-bit padded blocks over a valid/ready handshake
//  and runs 64 single-cycle rounds, one round per clk. Rounds use sha256_calculate_k/_w/_h.
//  Chains blocks of a multi-block message and returns the 256-bit digest on a held valid/ready output.
//  Sits between the message padder and the digest consumer.
// PARAMETERS
//  NUM_ROUNDS  64  rounds per block; legal 17..64; values below 64 are for debug/reduced-round tests only
// PORTS
//  clk           in   1    clock; all logic on posedge
//  rst           in   1    reset, synchronous, active-high
//  blk_valid     in   1    blk_data/blk_first/blk_last valid
//  blk_ready     out  1    controller can accept a block
//  blk_data      in   512  padded block; [511:480] = W0
//  blk_first     in   1    block starts a new message: load IV
//  blk_last      in   1    final block of the message
//  digest_valid  out  1    digest available
//  digest_ready  in   1    consumer accepts digest
//  digest        out  256  H0..H7; H0 in [255:224]
//  busy          out  1    FSM not in IDLE
//  abort         in   1    present only with SHA256_CTRL_ABORT_EN
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, blk_ready=0, digest_valid=0, digest=0, busy=0, round cnt=0,
//   chain_active=0, H regs=IV, working regs=0. Reset overrides every other event, including mid-round.
//  blk_ready=1 only in IDLE, one cycle after reset deassert. Transfer = blk_valid & blk_ready on an edge.
//  FSM:
//   IDLE  -> ROUND on transfer. Latch blk_data into window, blk_last into last_q.
//            If blk_first | !chain_active: H <= IV and a..h <= IV; else a..h <= H.
//   ROUND -> t = 0..NUM_ROUNDS-1, one round per cycle; K from sha256_calculate_k(t).
//            t<16: Wt=window[511:480], window <= {window[479:0], window[511:480]}.
//            t>=16: Wt=sha256_calculate_w(window), window <= {window[479:0], Wt}.
//            {a..h} <= sha256_calculate_h. Leave ROUND after t==NUM_ROUNDS-1.
//   FINAL -> Hi <= Hi + working_i, each word mod 2^32 with no carry between words.
//            If last_q: digest <= sum, chain_active=0, go to DONE. Else chain_active=1, go to IDLE.
//   DONE  -> digest_valid=1. digest is stable while digest_ready=0.
//            On digest_ready: digest_valid=0 and next state IDLE. digest keeps its value until the next load.
//  Latency: transfer edge E0; rounds on E1..E64; FINAL on E65; digest_valid is high after E65.
//   The next block can be accepted on E66 at the earliest. Throughput is 1 block per 66 clk.
//  blk_first=0 with chain_active=0 is treated as first (IV load); no error flag.
//  blk_first=1 while chain_active=1 discards the chain and restarts from IV.
//  blk_valid is ignored outside IDLE. Input fields are sampled only on the transfer edge.
//  digest_ready while digest_valid=0 has no effect.
// CONFIGURATION
//  SHA256_CTRL_ABORT_EN defined:
//   - abort port exists. abort=1 in ROUND/FINAL/DONE -> next state IDLE.
//   - chain_active=0, digest_valid=0, no H update. digest holds its old value.
//   - abort in IDLE is a no-op. If abort and rst are both high, rst wins.
//  SHA256_CTRL_ABORT_EN not defined: no abort port. A block always runs to completion.
// TESTING
//  1 "abc" one block (first=1,last=1, 0x61626380..0x18) -> digest_valid after E65,
//    digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  2 Empty message, one block 0x80000000..0 -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//  3 448-bit "abcdbcdecdefdefg...nopq" two blocks (first=1,last=0 then first=0,last=1)
//    -> no digest_valid after block 1; 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  4 digest_ready low for 10 cycles after digest_valid, blk_valid held high
//    -> digest stable, blk_ready=0 throughout; next block accepted the cycle after digest_ready.
//  5 rst pulsed at round 30 of the "abc" block -> outputs at reset values next cycle.
//    Re-sent "abc" -> correct digest; no chained state carried over.
//  6 (ABORT_EN) abort at round 40 of block 1 of test 3 -> IDLE, no digest_valid.
//    Block 2 sent with first=0 -> IV-based hash of that block alone.

Source files
------------

// File: rtl/sha256_block_ctrl.sv
// Iterative SHA-256 compression controller: one round per clock, multi-block chaining, held digest output.
// Optional abort input enabled by defining SHA256_CTRL_ABORT_EN.
module sha256_block_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy
`ifdef SHA256_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [6:0] LAST_RND = 7'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sha256_calculate_k(input logic [5:0] t);
    sha256_calculate_k = K_TAB[t];
  endfunction

  // Window holds W[t-16] in the top word down to W[t-1] in the bottom word.
  function automatic logic [31:0] sha256_calculate_w(input logic [511:0] win);
    logic [31:0] w16, w15, w7, w2, s0, s1;
    w16 = win[511:480];
    w15 = win[479:448];
    w7  = win[223:192];
    w2  = win[63:32];
    s0  = rotr(w15, 7) ^ rotr(w15, 18) ^ (w15 >> 3);
    s1  = rotr(w2, 17) ^ rotr(w2, 19) ^ (w2 >> 10);
    sha256_calculate_w = s1 + w7 + s0 + w16;
  endfunction

  function automatic logic [255:0] sha256_calculate_h(input logic [255:0] s,
                                                      input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, bs0, bs1, ch, maj;
    {a, b, c, d, e, f, g, h} = s;
    bs1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    ch  = (e & f) ^ (~e & g);
    t1  = h + bs1 + ch + k + w;
    bs0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2  = bs0 + maj;
    sha256_calculate_h = {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  state_t         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [511:0]   win_q, win_d;
  logic [255:0]   wk_q, wk_d;
  logic [255:0]   h_q, h_d;
  logic [255:0]   digest_q, digest_d;
  logic           last_q, last_d;
  logic           chain_q, chain_d;
  logic           blk_ready_q, digest_valid_q, busy_q;
  logic [255:0]   sum;
  logic [31:0]    wt;
  logic           xfer;

  assign blk_ready    = blk_ready_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;
  assign busy         = busy_q;

  assign xfer = blk_valid & blk_ready_q;
  // During the first 16 rounds the window simply rotates, so both cases shift in wt.
  assign wt   = (cnt_q < 7'd16) ? win_q[511:480] : sha256_calculate_w(win_q);

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) sum[i*32 +: 32] = h_q[i*32 +: 32] + wk_q[i*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    wk_d     = wk_q;
    h_d      = h_q;
    digest_d = digest_q;
    last_d   = last_q;
    chain_d  = chain_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = ROUND;
          cnt_d   = '0;
          win_d   = blk_data;
          last_d  = blk_last;
          if (blk_first || !chain_q) begin
            h_d  = IV;
            wk_d = IV;
          end else begin
            wk_d = h_q;
          end
        end
      end
      ROUND: begin
        wk_d  = sha256_calculate_h(wk_q, sha256_calculate_k(cnt_q[5:0]), wt);
        win_d = {win_q[479:0], wt};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == LAST_RND) begin
          state_d = FINAL;
          cnt_d   = '0;
        end
      end
      FINAL: begin
        h_d = sum;
        if (last_q) begin
          digest_d = sum;
          chain_d  = 1'b0;
          state_d  = DONE;
        end else begin
          chain_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      DONE: begin
        if (digest_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SHA256_CTRL_ABORT_EN
    // Abort drops the message entirely: no H update, chain broken, old digest retained.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      chain_d  = 1'b0;
      h_d      = h_q;
      digest_d = digest_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      win_q          <= '0;
      wk_q           <= '0;
      h_q            <= IV;
      digest_q       <= '0;
      last_q         <= 1'b0;
      chain_q        <= 1'b0;
      blk_ready_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      win_q          <= win_d;
      wk_q           <= wk_d;
      h_q            <= h_d;
      digest_q       <= digest_d;
      last_q         <= last_d;
      chain_q        <= chain_d;
      blk_ready_q    <= (state_d == IDLE);
      digest_valid_q <= (state_d == DONE);
      busy_q         <= (state_d != IDLE);
    end
  end

endmodule
